// File: rtl/seq_mult_shifter.sv
// seq_mult_shifter: partial-product alignment shifter for the 8x8 sequential
// multiplier. Places an IN_W-bit nibble product at offset 0, IN_W/2 or IN_W
// inside a 2*IN_W word. The result is registered with one cycle of latency,
// a valid strobe that follows the load enable, and a registered zero flag.
//
// Optional feature macro: SHIFTER_ILLEGAL_FLAG_EN
//   When this macro is defined, the module adds the registered output
//   illegal_cntrl. It flags a load that captured the unused select code 2'b11.
//   The data path behaves the same with or without the macro.
//
// IN_W must be even and >= 2 so that the half-width offset is a whole
// number of bits.

module seq_mult_shifter #(
  parameter int IN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [IN_W-1:0]   inp,
  input  logic [1:0]        shift_cntrl,
  output logic [2*IN_W-1:0] shift_out,
  output logic              out_valid,
  output logic              zero_out
`ifdef SHIFTER_ILLEGAL_FLAG_EN
  ,
  output logic              illegal_cntrl
`endif
);

  localparam int OUT_W  = 2 * IN_W;
  localparam int HALF_W = IN_W / 2;

  // Select codes for the alignment offset.
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_FULL = 2'b10;
  localparam logic [1:0] SEL_BAD  = 2'b11;

  logic [OUT_W-1:0] w_inpExt;
  logic [OUT_W-1:0] w_aligned;
  logic             w_alignedZero;

  logic [OUT_W-1:0] r_shiftOut;
  logic             r_valid;
  logic             r_zero;

  // Zero-extend the operand to the output width. The product is unsigned,
  // so the upper half is always filled with zeros.
  assign w_inpExt = {{IN_W{1'b0}}, inp};

  // Align the operand according to the select code. Code 11 is not a real
  // offset, so it falls back to no shift. Even a full IN_W shift of an
  // all-ones operand fits in OUT_W, so no bits are lost.
  always_comb begin
    w_aligned = w_inpExt;
    case (shift_cntrl)
      SEL_HALF: w_aligned = w_inpExt << HALF_W;
      SEL_FULL: w_aligned = w_inpExt << IN_W;
      default:  w_aligned = w_inpExt;
    endcase
  end

  assign w_alignedZero = (w_aligned == '0);

  // Result register. A load captures the aligned word and its zero flag.
  // Without a load, the word and flag hold while valid drops.
  // Reset clears everything at once, so a result that was in flight when
  // reset asserted is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shiftOut <= '0;
      r_valid    <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      r_valid <= en;
      if (en) begin
        r_shiftOut <= w_aligned;
        r_zero     <= w_alignedZero;
      end
    end
  end

  assign shift_out = r_shiftOut;
  assign out_valid = r_valid;
  assign zero_out  = r_zero;

`ifdef SHIFTER_ILLEGAL_FLAG_EN
  logic r_illegal;

  // Illegal-code flag. Every load updates it: it is set when the load
  // captured code 11 and cleared for any other code. It holds between loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (en) begin
      r_illegal <= (shift_cntrl == SEL_BAD);
    end
  end

  assign illegal_cntrl = r_illegal;
`else
  // Without the flag, the unused code needs no handling. Referencing the
  // constant here keeps its meaning documented in one place.
  logic w_unusedSel;
  assign w_unusedSel = (SEL_BAD == 2'b11) & (SEL_ZERO == 2'b00);
`endif

endmodule

// File: tb/tb_seq_mult_shifter.sv
// tb_seq_mult_shifter: self-checking bench for seq_mult_shifter.
// It runs a directed vector table, reset sequences, an exhaustive sweep and
// random traffic. All of these are checked against an arithmetic model.

module tb_seq_mult_shifter;

  localparam int IN_W  = 8;
  localparam int OUT_W = 2 * IN_W;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [IN_W-1:0]  inp;
  logic [1:0]       shift_cntrl;
  logic [OUT_W-1:0] shift_out;
  logic             out_valid;
  logic             zero_out;
`ifdef SHIFTER_ILLEGAL_FLAG_EN
  logic             illegal_cntrl;
  logic             expIllegal;
`endif

  int checks;
  int errors;

  logic [OUT_W-1:0] expShift;
  logic             expValid;
  logic             expZero;

  typedef struct {
    logic             en;
    logic [IN_W-1:0]  inp;
    logic [1:0]       ctl;
    logic [OUT_W-1:0] expShift;
    logic             expValid;
    logic             expZero;
  } vec_t;

  vec_t vecs[12];

  seq_mult_shifter #(.IN_W(IN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .inp         (inp),
    .shift_cntrl (shift_cntrl)
    ,
    .shift_out   (shift_out),
    .out_valid   (out_valid),
    .zero_out    (zero_out)
`ifdef SHIFTER_ILLEGAL_FLAG_EN
    ,
    .illegal_cntrl (illegal_cntrl)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference alignment: multiply the operand by 1, 16 or 256.
  // Code 11 behaves like code 00.
  function automatic logic [OUT_W-1:0] refAlign(input logic [IN_W-1:0] a, input logic [1:0] c);
    int unsigned mult;
    mult = (c == 2'd1) ? 16 : (c == 2'd2) ? 256 : 1;
    return OUT_W'(int'(a) * int'(mult));
  endfunction

  // Drive one cycle of inputs, let the edge pass, and advance the model.
  task automatic applyStimulus(input logic e, input logic [IN_W-1:0] a, input logic [1:0] c);
    en = e;
    inp = a;
    shift_cntrl = c;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      expShift = '0;
      expValid = 1'b0;
      expZero  = 1'b0;
`ifdef SHIFTER_ILLEGAL_FLAG_EN
      expIllegal = 1'b0;
`endif
    end else begin
      expValid = e;
      if (e) begin
        expShift = refAlign(a, c);
        expZero  = (expShift == '0);
`ifdef SHIFTER_ILLEGAL_FLAG_EN
        expIllegal = (c == 2'b11);
`endif
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [OUT_W-1:0] eS, input logic eV, input logic eZ);
    checks++;
    if (shift_out !== eS) begin
      errors++;
      $display("[TB] FAIL %s shift_out: got %h expected %h", name, shift_out, eS);
    end
    checks++;
    if (out_valid !== eV) begin
      errors++;
      $display("[TB] FAIL %s out_valid: got %b expected %b", name, out_valid, eV);
    end
    checks++;
    if (zero_out !== eZ) begin
      errors++;
      $display("[TB] FAIL %s zero_out: got %b expected %b", name, zero_out, eZ);
    end
`ifdef SHIFTER_ILLEGAL_FLAG_EN
    checks++;
    if (illegal_cntrl !== expIllegal) begin
      errors++;
      $display("[TB] FAIL %s illegal_cntrl: got %b expected %b", name, illegal_cntrl, expIllegal);
    end
`endif
  endtask

  initial begin
    checks = 0;
    errors = 0;
    expShift = '0;
    expValid = 1'b0;
    expZero  = 1'b0;
`ifdef SHIFTER_ILLEGAL_FLAG_EN
    expIllegal = 1'b0;
`endif

    vecs[0]  = '{1'b1, 8'hF0, 2'd0, 16'h00F0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'h55, 2'd1, 16'h0550, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 8'h33, 2'd2, 16'h3300, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 8'hCC, 2'd3, 16'h00CC, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h00, 2'd2, 16'h0000, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 8'hAB, 2'd1, 16'h0000, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h12, 2'd2, 16'h0000, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'hFF, 2'd2, 16'hFF00, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'hFF, 2'd1, 16'h0FF0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h01, 2'd0, 16'h0001, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h80, 2'd2, 16'h0001, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h80, 2'd2, 16'h8000, 1'b1, 1'b0};

    // Power-on reset. Loads attempted during reset must be ignored.
    rst_n = 1'b0;
    en = 1'b1;
    inp = 8'h5A;
    shift_cntrl = 2'd1;
    #2;
    checkOutput("reset_async", 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h5A, 2'd1);
    checkOutput("reset_en_ignored", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Directed vector table, applied back to back.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].en, vecs[i].inp, vecs[i].ctl);
      checkOutput($sformatf("vec%0d", i), vecs[i].expShift, vecs[i].expValid, vecs[i].expZero);
    end

    // Mid-cycle reset after a valid result: outputs clear without an edge.
    applyStimulus(1'b1, 8'h77, 2'd2);
    checkOutput("pre_reset_load", 16'h7700, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    expShift = '0;
    expValid = 1'b0;
    expZero  = 1'b0;
`ifdef SHIFTER_ILLEGAL_FLAG_EN
    expIllegal = 1'b0;
`endif
    checkOutput("midcycle_reset", 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3C, 2'd1);
    checkOutput("reset_held", 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h3C, 2'd1);
    checkOutput("post_reset_idle", 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h3C, 2'd1);
    checkOutput("post_reset_first", 16'h03C0, 1'b1, 1'b0);

    // Exhaustive sweep: every operand with every select code.
    for (int a = 0; a < 256; a++) begin
      for (int c = 0; c < 4; c++) begin
        applyStimulus(1'b1, IN_W'(a), 2'(c));
        checkOutput($sformatf("exh_%02h_%0d", a, c), expShift, expValid, expZero);
      end
    end

    // Random traffic with sparse enables, checked against the model.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 3) != 0), IN_W'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      checkOutput($sformatf("rand%0d", n), expShift, expValid, expZero);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
